// File: rtl/projectile_motion_pkg.sv
// projectile_motion_pkg
// Shared definitions for the projectile motion block:
//   - fixed-point format of the position registers (Q11.4)
//   - default screen geometry
//   - flight FSM state type
//   - helper that turns a Q11.4 coordinate into a clamped pixel index
package projectile_motion_pkg;

    localparam int FRAC_BITS    = 4;
    localparam int POS_W        = 15;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        EXIT = 2'd2
    } state_t;

    // Integer pixel of a Q11.4 value (arithmetic shift floors toward -inf),
    // clamped into 0..limit-1 so the renderer never sees an off-screen index.
    function automatic int clampPx(input int q, input int limit);
        int p;
        p = q >>> FRAC_BITS;
        if (p < 0) begin
            return 0;
        end
        if (p >= limit) begin
            return limit - 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/projectile_motion_if.sv
// projectile_motion_if
// Launch/control inputs and sprite position outputs of projectile_motion.
//   i_launch             start a flight (honoured only when idle)
//   i_init_x / i_init_y  start position, px, unsigned
//   i_init_vx / i_init_vy signed start velocity, 1/16 px per step
//   i_width / i_height   sprite size, px
//   i_freeze             pause the physics
//   o_posx / o_posy      clamped sprite position, px
//   o_active             high while the sprite is flying
//   o_done               one-cycle pulse when the sprite has left the screen
// master: the launcher side, slave: the projectile_motion block.
interface projectile_motion_if;

    logic               i_launch;
    logic        [9:0]  i_init_x;
    logic        [8:0]  i_init_y;
    logic signed [7:0]  i_init_vx;
    logic signed [7:0]  i_init_vy;
    logic        [9:0]  i_width;
    logic        [8:0]  i_height;
    logic               i_freeze;
    logic        [9:0]  o_posx;
    logic        [8:0]  o_posy;
    logic               o_active;
    logic               o_done;

    modport master (
        output i_launch, i_init_x, i_init_y, i_init_vx, i_init_vy,
               i_width, i_height, i_freeze,
        input  o_posx, o_posy, o_active, o_done
    );

    modport slave (
        input  i_launch, i_init_x, i_init_y, i_init_vx, i_init_vy,
               i_width, i_height, i_freeze,
        output o_posx, o_posy, o_active, o_done
    );

endinterface

// File: rtl/projectile_motion_step_tick.sv
// projectile_motion_step_tick
// Physics step timer: counts 0..TICK_DIV-1 while enabled and raises o_tick
// during the last count, so the step executes on the edge where it wraps.
//   clk, rst  system clock, synchronous active-high reset
//   i_en      count this cycle (low holds the count, e.g. while frozen)
//   i_clr     force the count back to zero
//   o_tick    one-cycle step strobe
module projectile_motion_step_tick #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running divider that only advances when enabled and wraps on the
    // step cycle; clear has the same effect as reset so a new flight always
    // starts a full period away from its first step.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_tick = i_en && (r_count == LAST);

endmodule

// File: rtl/projectile_motion.sv
// projectile_motion
// Ballistic position generator for one sprite. A launch loads a start
// position and velocity; every TICK_DIV cycles the position advances by the
// velocity and gravity is added to vy (saturating at VY_MAX). The flight ends
// with a one-cycle done pulse once the sprite has left the left, right or
// bottom edge. Leaving through the top is allowed (the sprite falls back).
//   clk, rst  system clock, synchronous active-high reset
//   bus       projectile_motion_if.slave (launch/init/freeze in, pos/status out)
// i_height is carried on the bus for the renderer; the exit test only needs
// the top-left corner against the bottom edge, so it is not used here.
module projectile_motion
    import projectile_motion_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int GRAVITY  = 4,
    parameter int VY_MAX   = 127,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                rst,
    projectile_motion_if.slave  bus
);

    state_t                    r_state;
    state_t                    w_stateNext;

    logic signed [POS_W-1:0]   r_x;
    logic signed [POS_W-1:0]   r_y;
    logic signed [7:0]         r_vx;
    logic signed [8:0]         r_vy;

    logic        [9:0]         r_posx;
    logic        [8:0]         r_posy;
    logic                      r_active;
    logic                      r_done;

    logic                      w_tick;
    logic                      w_launchGo;
    logic                      w_oob;
    logic                      w_activeNext;
    logic                      w_doneNext;
    logic signed [8:0]         w_vyNext;
    int                        w_xSum;
    int                        w_ySum;
    int                        w_vySum;
    int                        w_xPx;
    int                        w_yPx;

    assign w_launchGo = (r_state == IDLE) && bus.i_launch;

    projectile_motion_step_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_stepTick (
        .clk    (clk),
        .rst    (rst),
        .i_en   ((r_state == FLY) && !bus.i_freeze),
        .i_clr  (r_state != FLY),
        .o_tick (w_tick)
    );

    // Candidate next physics state, computed wide (as int) so the exit test
    // and the clamp see the true position even if it has run past the range
    // of the 15-bit registers on the final step.
    always_comb begin
        w_xSum  = int'(r_x) + int'(r_vx);
        w_ySum  = int'(r_y) + int'(r_vy);
        w_vySum = int'(r_vy) + GRAVITY;
        w_vyNext = (w_vySum > VY_MAX) ? 9'(VY_MAX) : 9'(w_vySum);
        w_xPx   = w_xSum >>> FRAC_BITS;
        w_yPx   = w_ySum >>> FRAC_BITS;
        w_oob   = ((w_xPx + int'(bus.i_width)) <= 0) ||
                  (w_xPx >= SCREEN_W) ||
                  (w_yPx >= SCREEN_H);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: launch only matters when idle, the exit decision is
    // made on the step edge from the freshly computed position, and EXIT
    // lasts exactly one cycle so done is a single pulse.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (bus.i_launch)    w_stateNext = FLY;
            FLY:     if (w_tick && w_oob) w_stateNext = EXIT;
            EXIT:                         w_stateNext = IDLE;
            default:                      w_stateNext = IDLE;
        endcase
    end

    // Output decode from the next state so the registered flags line up with
    // the state they describe.
    always_comb begin
        w_activeNext = (w_stateNext == FLY);
        w_doneNext   = (w_stateNext == EXIT);
    end

    // Registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_active <= w_activeNext;
            r_done   <= w_doneNext;
        end
    end

    // Physics registers and the pixel outputs. The outputs are refreshed
    // together with the position, so they hold their last value while idle,
    // frozen or between steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_vx   <= '0;
            r_vy   <= '0;
            r_posx <= '0;
            r_posy <= '0;
        end else if (w_launchGo) begin
            r_x    <= POS_W'(int'(bus.i_init_x) << FRAC_BITS);
            r_y    <= POS_W'(int'(bus.i_init_y) << FRAC_BITS);
            r_vx   <= bus.i_init_vx;
            r_vy   <= 9'(bus.i_init_vy);
            r_posx <= 10'(clampPx(int'(bus.i_init_x) << FRAC_BITS, SCREEN_W));
            r_posy <= 9'(clampPx(int'(bus.i_init_y) << FRAC_BITS, SCREEN_H));
        end else if (w_tick) begin
            r_x    <= POS_W'(w_xSum);
            r_y    <= POS_W'(w_ySum);
            r_vy   <= w_vyNext;
            r_posx <= 10'(clampPx(w_xSum, SCREEN_W));
            r_posy <= 9'(clampPx(w_ySum, SCREEN_H));
        end
    end

    assign bus.o_posx   = r_posx;
    assign bus.o_posy   = r_posy;
    assign bus.o_active = r_active;
    assign bus.o_done   = r_done;

endmodule

// File: tb/tb_projectile_motion.sv
// tb_projectile_motion
// Self-checking bench for projectile_motion. A behavioural flight model
// (integer 1/16 px coordinates, floor division to pixels) predicts the
// sprite position and flags after every step; directed throws are followed
// by randomized ones.
module tb_projectile_motion;

    localparam int TICK_DIV = 4;
    localparam int GRAVITY  = 4;
    localparam int VY_MAX   = 127;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MAX_STEPS = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    projectile_motion_if bus ();

    projectile_motion #(
        .TICK_DIV (TICK_DIV),
        .GRAVITY  (GRAVITY),
        .VY_MAX   (VY_MAX),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int ex, input int ey, input int ea, input int ed);
        checkOutput({tag, ".posx"},   int'(bus.o_posx),   ex);
        checkOutput({tag, ".posy"},   int'(bus.o_posy),   ey);
        checkOutput({tag, ".active"}, int'(bus.o_active), ea);
        checkOutput({tag, ".done"},   int'(bus.o_done),   ed);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Pixel from a 1/16 px coordinate, rounding toward minus infinity.
    function automatic int pxOf(input int q);
        if (q >= 0) return q / 16;
        return -((-q + 15) / 16);
    endfunction

    function automatic int clampTo(input int v, input int size);
        if (v < 0) return 0;
        if (v > size - 1) return size - 1;
        return v;
    endfunction

    function automatic bit isOob(input int qx, input int qy, input int w);
        return (pxOf(qx) + w <= 0) || (pxOf(qx) >= SCREEN_W) || (pxOf(qy) >= SCREEN_H);
    endfunction

    // Present a one-cycle launch with the given start conditions.
    task automatic applyStimulus(input int x0, input int y0, input int vx0, input int vy0, input int w);
        bus.i_init_x  = 10'(x0);
        bus.i_init_y  = 9'(y0);
        bus.i_init_vx = 8'(vx0);
        bus.i_init_vy = 8'(vy0);
        bus.i_width   = 10'(w);
        bus.i_height  = 9'(16);
        bus.i_launch  = 1'b1;
        nextCycle();
        bus.i_launch  = 1'b0;
    endtask

    // Launch and follow one flight step by step against the model.
    // freezeStep: step before which freeze is held for freezeLen cycles (0 = none),
    // with a stray launch pulse on the first frozen cycle.
    // resetStep: step after which reset is asserted (0 = none).
    task automatic flight(input string name, input int x0, input int y0, input int vx0, input int vy0,
                          input int w, input int freezeStep, input int freezeLen, input int resetStep);
        int mx, my, mvy, ex, ey, step;
        bit gone;
        applyStimulus(x0, y0, vx0, vy0, w);
        ex = clampTo(x0, SCREEN_W);
        ey = clampTo(y0, SCREEN_H);
        checkAll({name, ".launch"}, ex, ey, 1, 0);
        mx = x0 * 16;
        my = y0 * 16;
        mvy = vy0;
        gone = 1'b0;
        step = 0;
        while (!gone && step < MAX_STEPS) begin
            for (int c = 1; c < TICK_DIV; c++) begin
                if (c == 1 && step + 1 == freezeStep) begin
                    bus.i_freeze  = 1'b1;
                    bus.i_init_x  = 10'(7);
                    bus.i_init_y  = 9'(7);
                    bus.i_launch  = 1'b1;
                    for (int f = 0; f < freezeLen; f++) begin
                        nextCycle();
                        bus.i_launch = 1'b0;
                        checkAll({name, ".frozen"}, ex, ey, 1, 0);
                    end
                    bus.i_freeze = 1'b0;
                end
                nextCycle();
                checkAll({name, ".between"}, ex, ey, 1, 0);
            end
            nextCycle();
            step++;
            mx  = mx + vx0;
            my  = my + mvy;
            mvy = (mvy + GRAVITY > VY_MAX) ? VY_MAX : mvy + GRAVITY;
            ex  = clampTo(pxOf(mx), SCREEN_W);
            ey  = clampTo(pxOf(my), SCREEN_H);
            gone = isOob(mx, my, w);
            checkAll($sformatf("%s.step%0d", name, step), ex, ey, gone ? 0 : 1, gone ? 1 : 0);
            if (!gone && step == resetStep) begin
                rst = 1'b1;
                nextCycle();
                rst = 1'b0;
                checkAll({name, ".midReset"}, 0, 0, 0, 0);
                return;
            end
        end
        if (gone) begin
            nextCycle();
            checkAll({name, ".afterExit"}, ex, ey, 0, 0);
        end else begin
            rst = 1'b1;
            nextCycle();
            rst = 1'b0;
        end
    endtask

    initial begin
        int rx, ry, rvx, rvy, rw, rfs, rfl;
        bus.i_launch  = 1'b0;
        bus.i_init_x  = '0;
        bus.i_init_y  = '0;
        bus.i_init_vx = '0;
        bus.i_init_vy = '0;
        bus.i_width   = '0;
        bus.i_height  = '0;
        bus.i_freeze  = 1'b0;
        rst = 1'b1;
        repeat (3) nextCycle();
        checkAll("reset", 0, 0, 0, 0);

        bus.i_init_x = 10'(300);
        bus.i_init_y = 9'(200);
        bus.i_launch = 1'b1;
        nextCycle();
        checkAll("resetBeatsLaunch", 0, 0, 0, 0);
        bus.i_launch = 1'b0;
        rst = 1'b0;

        bus.i_freeze = 1'b1;
        repeat (3) nextCycle();
        checkAll("idleFreeze", 0, 0, 0, 0);
        bus.i_freeze = 1'b0;

        flight("upThrow",   100, 400,  32,  -64, 16, 0,  0, 0);
        flight("leftExit",    5, 200, -48,    0, 10, 0,  0, 0);
        flight("bottomExit",100, 470,   0,   80, 20, 0,  0, 0);
        flight("topOver",   300,  10,   0, -127, 16, 0,  0, 0);
        flight("freeze",    200, 240,  16,  -32, 16, 3, 10, 0);
        flight("saturate",  320, 100,   0,  120, 16, 0,  0, 0);
        flight("launchOob", 650, 100,   0,    0, 16, 0,  0, 0);
        flight("midReset",   50,  50,  20,  -20, 16, 0,  0, 3);
        flight("relaunch",  400, 300, -20,  -40, 24, 0,  0, 0);

        for (int i = 0; i < 20; i++) begin
            rx  = int'($urandom_range(0, 700));
            ry  = int'($urandom_range(0, 511));
            rvx = int'($urandom_range(0, 255)) - 128;
            rvy = int'($urandom_range(0, 255)) - 128;
            rw  = int'($urandom_range(1, 64));
            rfs = 0;
            rfl = 0;
            if ($urandom_range(0, 3) == 0) begin
                rfs = int'($urandom_range(1, 4));
                rfl = int'($urandom_range(1, 12));
            end
            flight($sformatf("rand%0d", i), rx, ry, rvx, rvy, rw, rfs, rfl, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
